// File: rtl/pll_supervisor_pkg.sv
// Shared types and sizing helpers for the PLL supervisor: FSM state encoding,
// relock counter width and the shared-counter width calculation.
package pll_supervisor_pkg;

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        FILTER,
        HOLD,
        RUN
    } sup_state_t;

    localparam int RELOCK_W = 8;

    // One bit above what the largest interval needs, so a terminal count never wraps.
    function automatic int cnt_width(input int rst_cycles,
                                     input int filter_cycles,
                                     input int hold_cycles,
                                     input int timeout_cycles);
        int largest;
        largest = rst_cycles;
        if (filter_cycles > largest) largest = filter_cycles;
        if (hold_cycles > largest) largest = hold_cycles;
        if (timeout_cycles > largest) largest = timeout_cycles;
        return $clog2(largest) + 1;
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Parameterized flop chain with synchronous clear, used to bring an
// asynchronous level (PLL lock, or sys_rst_n in consumer domains) into clk.
module pll_lock_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/de10nano_pll_supervisor.sv
// PLL reset sequencer and lock supervisor on refclk; sole source of sys_rst_n/ready.
// Optional WAIT_LOCK retry timeout is built only when PLL_SUPERVISOR_TIMEOUT_EN is defined.
module de10nano_pll_supervisor
    import pll_supervisor_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_FILTER    = 8,
    parameter int HOLD_CYCLES    = 1024,
    parameter int LOCK_TIMEOUT   = 500000
) (
    input  logic                refclk,
    input  logic                rst_n,
    input  logic                pll_locked,
    output logic                pll_rst,
    output logic                sys_rst_n,
    output logic                ready,
    output logic                lost_lock,
    output logic [RELOCK_W-1:0] relock_count
);

    localparam int CNT_W = cnt_width(PLL_RST_CYCLES, LOCK_FILTER, HOLD_CYCLES, LOCK_TIMEOUT);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] FILTER_LAST = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
`ifdef PLL_SUPERVISOR_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
`endif

    sup_state_t          state;
    sup_state_t          state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic                armed;
    logic                locked_s;
    logic                lost_nxt;
    logic [RELOCK_W-1:0] relock_nxt;

    pll_lock_sync #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (locked_s)
    );

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt + 1'b1;
        lost_nxt   = 1'b0;
        relock_nxt = relock_count;

        case (state)
            RESET_PLL: begin
                // The first edge after reset release does not count, so pll_rst
                // spans PLL_RST_CYCLES full cycles after rst_n rises.
                if (!armed) begin
                    cnt_nxt = cnt;
                end else if (cnt == RST_LAST) begin
                    state_nxt = WAIT_LOCK;
                end
            end

            WAIT_LOCK: begin
                if (locked_s) begin
                    state_nxt = FILTER;
                end
`ifdef PLL_SUPERVISOR_TIMEOUT_EN
                else if (cnt == TIMEOUT_LAST) begin
                    state_nxt = RESET_PLL;
                end
`endif
            end

            FILTER: begin
                if (!locked_s) begin
                    state_nxt = WAIT_LOCK;
                end else if (cnt == FILTER_LAST) begin
                    state_nxt = HOLD;
                end
            end

            HOLD: begin
                if (!locked_s) begin
                    state_nxt = RESET_PLL;
                end else if (cnt == HOLD_LAST) begin
                    state_nxt = RUN;
                end
            end

            RUN: begin
                if (!locked_s) begin
                    state_nxt = RESET_PLL;
                    lost_nxt  = 1'b1;
                    if (relock_count != '1) begin
                        relock_nxt = relock_count + 1'b1;
                    end
                end
            end

            default: begin
                state_nxt = RESET_PLL;
            end
        endcase

        if (state_nxt != state) begin
            cnt_nxt = '0;
        end
    end

    // Outputs are decoded from the next state and registered, so each one
    // changes on the same edge as the state it belongs to.
    // NOTE: only flops exist here (no memories), so all of them take the synchronous reset.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state        <= RESET_PLL;
            cnt          <= '0;
            armed        <= 1'b0;
            pll_rst      <= 1'b1;
            sys_rst_n    <= 1'b0;
            ready        <= 1'b0;
            lost_lock    <= 1'b0;
            relock_count <= '0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            armed        <= 1'b1;
            pll_rst      <= (state_nxt == RESET_PLL);
            sys_rst_n    <= (state_nxt == RUN);
            ready        <= (state_nxt == RUN);
            lost_lock    <= lost_nxt;
            relock_count <= relock_nxt;
        end
    end

endmodule

// File: tb/tb_de10nano_pll_supervisor.sv
// Directed bench for de10nano_pll_supervisor; timeout expectations follow
// whether PLL_SUPERVISOR_TIMEOUT_EN is defined in this build.
module tb_de10nano_pll_supervisor;

    logic       refclk;
    logic       rst_n;
    logic       pll_locked;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic       lost_lock;
    logic [7:0] relock_count;

    int checks;
    int errors;
    int edge_idx;

    de10nano_pll_supervisor #(
        .SYNC_STAGES    (2),
        .PLL_RST_CYCLES (4),
        .LOCK_FILTER    (3),
        .HOLD_CYCLES    (8),
        .LOCK_TIMEOUT   (50)
    ) dut (
        .refclk       (refclk),
        .rst_n        (rst_n),
        .pll_locked   (pll_locked),
        .pll_rst      (pll_rst),
        .sys_rst_n    (sys_rst_n),
        .ready        (ready),
        .lost_lock    (lost_lock),
        .relock_count (relock_count)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    // Advance n edges; after each, outputs must equal the given constants.
    task automatic run_edges(input string tag, input int n,
                             input logic e_rst, input logic e_sys, input logic e_rdy,
                             input logic e_lost, input logic [7:0] e_cnt);
        for (int i = 0; i < n; i++) begin
            @(posedge refclk);
            #1;
            checks++;
            assert ({pll_rst, sys_rst_n, ready, lost_lock, relock_count} ===
                    {e_rst, e_sys, e_rdy, e_lost, e_cnt})
            else begin
                errors++;
                $error("FAIL %s edge %0d: observed pll_rst=%b sys_rst_n=%b ready=%b lost_lock=%b relock_count=%0d, expected pll_rst=%b sys_rst_n=%b ready=%b lost_lock=%b relock_count=%0d",
                       tag, edge_idx, pll_rst, sys_rst_n, ready, lost_lock, relock_count,
                       e_rst, e_sys, e_rdy, e_lost, e_cnt);
            end
            edge_idx++;
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        edge_idx   = 0;
        rst_n      = 1'b0;
        pll_locked = 1'b0;

        // Reset sequence and clean lock
        run_edges("reset_hold", 5, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        rst_n = 1'b1;
        edge_idx = 0;
        run_edges("pll_rst_pulse", 4, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        run_edges("wait_lock", 6, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        pll_locked = 1'b1;
        run_edges("lock_pending", 13, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        run_edges("clean_run", 8, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);

        // Lock loss in RUN at edge 31
        pll_locked = 1'b0;
        run_edges("loss_sync_delay", 2, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
        run_edges("loss_pulse", 1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1);
        run_edges("loss_pll_rst", 3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
        run_edges("loss_wait", 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
        pll_locked = 1'b1;
        run_edges("relock_pending", 13, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
        run_edges("relock_run", 2, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1);

        // Second loss in RUN, then loss during HOLD
        pll_locked = 1'b0;
        run_edges("loss2_sync_delay", 2, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1);
        run_edges("loss2_pulse", 1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd2);
        run_edges("loss2_pll_rst", 3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2);
        run_edges("loss2_wait", 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2);
        pll_locked = 1'b1;
        run_edges("to_hold", 6, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2);
        pll_locked = 1'b0;
        run_edges("hold_loss_delay", 2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2);
        run_edges("hold_loss_no_pulse", 1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2);
        run_edges("hold_loss_pll_rst", 3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2);
        run_edges("hold_loss_wait", 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2);

        // Reset asserted in the middle of HOLD
        pll_locked = 1'b1;
        run_edges("to_hold_again", 6, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2);
        rst_n = 1'b0;
        run_edges("reset_mid_hold", 1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        run_edges("reset_held_locked", 2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        pll_locked = 1'b0;
        run_edges("reset_held", 1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);

        // Glitch during FILTER: high on 10-11, low on 12, high from 13
        rst_n = 1'b1;
        edge_idx = 0;
        run_edges("g_pll_rst_pulse", 4, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        run_edges("g_wait_lock", 6, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        pll_locked = 1'b1;
        run_edges("g_first_high", 2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        pll_locked = 1'b0;
        run_edges("g_glitch_low", 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        pll_locked = 1'b1;
        run_edges("g_refilter", 13, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        run_edges("g_run", 4, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);

        // Lock never arrives
        rst_n = 1'b0;
        pll_locked = 1'b0;
        run_edges("t_reset", 2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        rst_n = 1'b1;
        edge_idx = 0;
        run_edges("t_pll_rst_pulse", 4, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        run_edges("t_wait1", 50, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
`ifdef PLL_SUPERVISOR_TIMEOUT_EN
        run_edges("t_retry1", 4, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        run_edges("t_wait2", 50, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        run_edges("t_retry2", 4, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        run_edges("t_wait3", 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
`else
        run_edges("t_no_retry", 120, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
